// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Lets two bus masters share one single-port, byte-lane RAM.
//   m0 : CPU core memory port. It has fixed priority.
//   m1 : secondary master, such as a UART loader or a DMA engine.
//
// m1 normally waits while m0 is requesting. A wait counter stops m1 from
// being starved: after MAX_WAIT consecutive stalled cycles, m1 is granted
// for one cycle. The arbiter also builds the RAM byte write strobes and a
// read-data-valid pulse for each master.
//
// Parameters
//   MAX_WAIT : number of stalled m1 cycles before m1 is force-granted
//              (0 = pure fixed priority, never forced)
//   ADDR_W   : address width of the masters and the RAM
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   mN_r / mN_w          read / write request from master N
//   mN_sz                access size (0 byte, 1 half, 2/3 word)
//   mN_addr, mN_wdata    byte address and write data
//   mN_rdata             read data (ram_rdata passed straight through)
//   mN_rvalid            pulses one cycle after an accepted read
//   mN_busy              request is stalled this cycle
//   ram_r / ram_w        RAM read / write enables
//   ram_addr, ram_wdata  RAM byte address and write data
//   ram_wstrb            RAM byte write enables
//   ram_rdata            RAM read data, valid the cycle after ram_r
// ---------------------------------------------------------------------------
module ram_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_r,
    input  logic              m0_w,
    input  logic [1:0]        m0_sz,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic [31:0]       m0_rdata,
    output logic              m0_rvalid,
    output logic              m0_busy,

    input  logic              m1_r,
    input  logic              m1_w,
    input  logic [1:0]        m1_sz,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic [31:0]       m1_rdata,
    output logic              m1_rvalid,
    output logic              m1_busy,

    output logic              ram_r,
    output logic              ram_w,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_wstrb,
    input  logic [31:0]       ram_rdata
);

    // The counter must be able to hold MAX_WAIT. It is always at least 1 bit
    // wide, so the MAX_WAIT=0 build still has a legal vector.
    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rd_pend_q,  rd_pend_d;
    logic             rd_owner_q, rd_owner_d;   // 0 = m0, 1 = m1

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic req0, req1;
    logic force_grant;
    logic g0, g1;

    assign req0 = m0_r | m0_w;
    assign req1 = m1_r | m1_w;

    assign force_grant = (MAX_WAIT != 0) && (wait_cnt_q == CNT_MAX);

    // Both grants are masked while rst is high. This makes every request
    // look stalled, and the RAM sees no enables during reset.
    assign g1 = !rst & req1 & (!req0 | force_grant);
    assign g0 = !rst & req0 & !g1;

    assign m0_busy = req0 & !g0;
    assign m1_busy = req1 & !g1;

    // -----------------------------------------------------------------------
    // RAM port mux. m0 stays on the bus when nobody is granted, so the core
    // address is always visible.
    // -----------------------------------------------------------------------
    logic [1:0] sel_sz;
    logic [1:0] sel_off;

    always_comb begin
        ram_addr  = m0_addr;
        ram_wdata = m0_wdata;
        sel_sz    = m0_sz;
        if (g1) begin
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
            sel_sz    = m1_sz;
        end
    end

    assign sel_off = ram_addr[1:0];
    assign ram_r   = (g0 & m0_r) | (g1 & m1_r);
    assign ram_w   = (g0 & m0_w) | (g1 & m1_w);

    // -----------------------------------------------------------------------
    // Write strobes: a base mask of 1, 2 or 4 lanes, shifted up by the byte
    // offset. Lanes shifted past bit 3 are dropped, so a misaligned access
    // is silently truncated.
    // -----------------------------------------------------------------------
    logic [2:0] lane_cnt;

    always_comb begin
        case (sel_sz)
            2'd0:    lane_cnt = 3'd1;
            2'd1:    lane_cnt = 3'd2;
            default: lane_cnt = 3'd4;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            // Lane gi is enabled when offset <= gi < offset + lane_cnt.
            assign ram_wstrb[gi] = ({1'b0, sel_off} <= 3'(gi)) &&
                                   (3'(gi) < ({1'b0, sel_off} + lane_cnt));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Wait counter: counts consecutive stalled m1 cycles and saturates at
    // MAX_WAIT. It clears on any m1 grant, so the next force needs a fresh
    // run of MAX_WAIT stalls.
    // -----------------------------------------------------------------------
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (req1 && !g1) begin
            if (wait_cnt_q != CNT_MAX) begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end else begin
            wait_cnt_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Read return tracking. The RAM registers its output, so data arrives
    // one cycle after the read. We remember whether a read was issued and
    // which master owns it.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_pend_d  = ram_r;
        rd_owner_d = g1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // A read issued just before rst rises has its return cycle inside reset.
    // The rst term suppresses that pulse.
    assign m0_rvalid = rd_pend_q & !rd_owner_q & !rst;
    assign m1_rvalid = rd_pend_q &  rd_owner_q & !rst;

    assign m0_rdata = ram_rdata;
    assign m1_rdata = ram_rdata;

endmodule
